ifid_buffer: RTL

Decoupling buffer between the fetch stage and the decode stage of the RV32I pipeline. Accepts one fetched packet (PC, PC+4, instruction) per cycle from fetch via a valid/ready handshake. Holds up to DEPTH packets in a small FIFO and presents the oldest packet to decode. Supports a synchronous flush for branch/jump redirects and substitutes a NOP bubble when empty.

---
 rtl/pipeline_pkg.sv | 23 ++
 rtl/ifid_buffer.sv | 81 ++++++++
 2 files changed

// File: rtl/pipeline_pkg.sv
// Shared IF/ID pipeline types: the fetched packet layout and the NOP bubble
// inserted whenever a stage has no real instruction to present.
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [31:0]     instr;
    } ifid_t;

    function automatic ifid_t ifid_bubble();
        ifid_t b;
        b.pc       = {XLEN{1'b0}};
        b.pc_plus4 = {XLEN{1'b0}};
        b.instr    = NOP_INSTR;
        return b;
    endfunction

endpackage

// File: rtl/ifid_buffer.sv
// Fetch-to-decode decoupling FIFO: valid/ready on both sides, flush on redirect,
// and a NOP bubble on the output whenever nothing is buffered.
module ifid_buffer
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  ifid_t                  in_pkt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output ifid_t                  out_pkt,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    ifid_t          mem_r [DEPTH];
    logic [PW-1:0]  rd_ptr_r;
    logic [PW-1:0]  wr_ptr_r;
    logic [PW:0]    count_r;
    logic           push_s;
    logic           pop_s;
    logic           in_ready_s;
    logic           out_valid_s;

    // in_ready looks only at occupancy, so a full buffer refuses even on a pop cycle
    assign in_ready_s  = (count_r < FULL_CNT);
    assign out_valid_s = (count_r != {(PW + 1){1'b0}});
    assign push_s      = in_valid && in_ready_s && !flush;
    assign pop_s       = out_valid_s && out_ready && !flush;

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign count     = count_r;

    // Pointer and occupancy state; flush has priority over push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW + 1){1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_r + (PW + 1)'(push_s) - (PW + 1)'(pop_s);
        end
    end

    // Packet storage; contents survive reset and flush, only pointers are cleared
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_pkt;
        end
    end

    // Present the oldest packet, or a bubble when empty
    always_comb begin
        out_pkt = ifid_bubble();
        if (out_valid_s) begin
            out_pkt = mem_r[rd_ptr_r];
        end else begin
            out_pkt = ifid_bubble();
        end
    end

endmodule
